// File: rtl/user_obi_mgr_arbiter.sv
// Two-requester OBI manager arbiter: round-robin on grants, in-order response routing
// through a small FIFO of granted requester indices, sticky flag for orphan responses.

package obi_pkg;
    typedef struct packed {
        int unsigned AddrWidth;
        int unsigned DataWidth;
        int unsigned IdWidth;
    } obi_cfg_t;

    localparam obi_cfg_t ObiDefaultConfig = '{AddrWidth: 32, DataWidth: 32, IdWidth: 1};

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [0:0]  aid;
    } obi_a_chan_t;

    typedef struct packed {
        logic        req;
        obi_a_chan_t a;
    } obi_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic [0:0]  rid;
        logic        err;
    } obi_r_chan_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        obi_r_chan_t r;
    } obi_rsp_t;
endpackage

module user_obi_mgr_arbiter #(
    parameter obi_pkg::obi_cfg_t ObiCfg         = obi_pkg::ObiDefaultConfig,
    parameter type               obi_req_t      = obi_pkg::obi_req_t,
    parameter type               obi_rsp_t      = obi_pkg::obi_rsp_t,
    parameter int unsigned       MaxOutstanding = 2
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  obi_req_t req0_i,
    output obi_rsp_t rsp0_o,
    input  obi_req_t req1_i,
    output obi_rsp_t rsp1_o,
    output obi_req_t mgr_req_o,
    input  obi_rsp_t mgr_rsp_i,
    output logic     busy_o,
    output logic     err_o
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

    if (MaxOutstanding < 1 || MaxOutstanding > 8) begin : g_bad_depth
        $error("MaxOutstanding must be in 1..8");
    end
    if (ObiCfg.DataWidth != $bits(mgr_rsp_i.r.rdata)) begin : g_bad_cfg
        $error("ObiCfg.DataWidth does not match the response rdata width");
    end

    logic [MaxOutstanding-1:0] fifo_q, fifo_d;
    logic [PtrW-1:0]           wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0]           cnt_q, cnt_d;
    logic                      prio_q, prio_d;
    logic                      err_q, err_d;
    logic                      busy_q;

    logic     sel, any_req, fifo_full, fifo_empty, hs, pop, orphan, head;
    obi_req_t mgr_req;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        any_req    = req0_i.req | req1_i.req;
        // Contention resolves by the pointer; a lone requester always wins.
        sel        = (req0_i.req & req1_i.req) ? prio_q : req1_i.req;
        fifo_full  = (cnt_q == CntW'(MaxOutstanding));
        fifo_empty = (cnt_q == '0);

        mgr_req     = sel ? req1_i : req0_i;
        mgr_req.req = any_req & ~fifo_full;

        hs     = mgr_req.req & mgr_rsp_i.gnt;
        pop    = mgr_rsp_i.rvalid & ~fifo_empty;
        orphan = mgr_rsp_i.rvalid & fifo_empty;
        head   = fifo_q[rptr_q];

        rsp0_o        = mgr_rsp_i;
        rsp0_o.gnt    = hs & ~sel;
        rsp0_o.rvalid = pop & ~head;
        rsp1_o        = mgr_rsp_i;
        rsp1_o.gnt    = hs & sel;
        rsp1_o.rvalid = pop & head;

        fifo_d = fifo_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (hs) begin
            fifo_d[wptr_q] = sel;
            wptr_d         = ptr_inc(wptr_q);
        end
        if (pop) rptr_d = ptr_inc(rptr_q);
        if (hs && !pop)      cnt_d = cnt_q + 1'b1;
        else if (pop && !hs) cnt_d = cnt_q - 1'b1;

        prio_d = hs ? ~sel : prio_q;
        err_d  = err_q | orphan;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fifo_q <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            prio_q <= 1'b0;
            err_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            fifo_q <= fifo_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            prio_q <= prio_d;
            err_q  <= err_d;
            busy_q <= (cnt_d != '0);
        end
    end

    assign mgr_req_o = mgr_req;
    assign busy_o    = busy_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_user_obi_mgr_arbiter.sv
// Directed bench for user_obi_mgr_arbiter: arbitration order, FIFO back-pressure,
// same-cycle push/pop, orphan responses and asynchronous reset.
module tb_user_obi_mgr_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    obi_pkg::obi_req_t req0, req1, mgr_req;
    obi_pkg::obi_rsp_t rsp0, rsp1, mgr_rsp;
    logic busy, err;
    int nvec = 0;
    int nerr = 0;
    int g0cnt = 0;
    int g1cnt = 0;

    always #5 clk = ~clk;

    user_obi_mgr_arbiter #(.MaxOutstanding(2)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .req0_i   (req0),
        .rsp0_o   (rsp0),
        .req1_i   (req1),
        .rsp1_o   (rsp1),
        .mgr_req_o(mgr_req),
        .mgr_rsp_i(mgr_rsp),
        .busy_o   (busy),
        .err_o    (err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drv(input logic r0, input logic r1, input logic g, input logic rv,
                       input logic [31:0] rd);
        req0.req         = r0;
        req1.req         = r1;
        mgr_rsp.gnt      = g;
        mgr_rsp.rvalid   = rv;
        mgr_rsp.r.rdata  = rd;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_g(input string tag, input logic e0, input logic e1);
        chk({tag, ".gnt0"}, 32'(rsp0.gnt), 32'(e0));
        chk({tag, ".gnt1"}, 32'(rsp1.gnt), 32'(e1));
    endtask

    task automatic chk_rv(input string tag, input logic e0, input logic e1);
        chk({tag, ".rv0"}, 32'(rsp0.rvalid), 32'(e0));
        chk({tag, ".rv1"}, 32'(rsp1.rvalid), 32'(e1));
    endtask

    initial begin
        req0 = '0;
        req1 = '0;
        mgr_rsp = '0;
        req0.a.addr  = 32'h1000_0000;
        req0.a.wdata = 32'h0000_00A0;
        req1.a.addr  = 32'h2000_0000;
        req1.a.wdata = 32'h0000_00B1;
        rst_n = 1'b0;
        drv(0, 0, 0, 0, 32'h0);
        chk("rst.busy", 32'(busy), 0);
        chk("rst.err", 32'(err), 0);
        chk("rst.mreq", 32'(mgr_req.req), 0);
        chk_g("rst", 0, 0);
        chk_rv("rst", 0, 0);
        step();
        rst_n = 1'b1;
        step();

        // Alternating grants with rvalid one cycle behind each grant
        for (int i = 0; i < 4; i++) begin
            drv(1, 1, 1, i > 0, 32'hA000_0000 + i);
            chk_g("alt", (i % 2) == 0, (i % 2) == 1);
            chk_rv("alt", i > 0 && ((i - 1) % 2) == 0, i > 0 && ((i - 1) % 2) == 1);
            chk("alt.addr", mgr_req.a.addr, (i % 2) ? 32'h2000_0000 : 32'h1000_0000);
            g0cnt += int'(rsp0.gnt);
            g1cnt += int'(rsp1.gnt);
            step();
        end
        chk("alt.n0", g0cnt, 2);
        chk("alt.n1", g1cnt, 2);
        drv(0, 0, 0, 1, 32'hB000_0004);
        chk_rv("alt.last", 0, 1);
        chk("alt.rdata", rsp1.r.rdata, 32'hB000_0004);
        step();
        chk("alt.busy", 32'(busy), 0);

        // Request without gnt: nothing pushed, pointer holds
        drv(1, 1, 0, 0, 32'h0);
        chk("nogt.mreq", 32'(mgr_req.req), 1);
        chk_g("nogt", 0, 0);
        step();
        chk("nogt.busy", 32'(busy), 0);

        // Fill to MaxOutstanding, then back-pressure
        drv(1, 1, 1, 0, 32'h0);
        chk_g("fill1", 1, 0);
        step();
        chk("fill1.busy", 32'(busy), 1);
        drv(1, 1, 1, 0, 32'h0);
        chk_g("fill2", 0, 1);
        step();
        drv(1, 1, 1, 0, 32'h0);
        chk("full.mreq", 32'(mgr_req.req), 0);
        chk_g("full", 0, 0);
        chk("full.busy", 32'(busy), 1);
        step();
        drv(1, 1, 1, 1, 32'h5555_0001);
        chk("fullpop.mreq", 32'(mgr_req.req), 0);
        chk_rv("fullpop", 1, 0);
        chk("fullpop.rdata", rsp0.r.rdata, 32'h5555_0001);
        step();
        drv(1, 1, 1, 0, 32'h0);
        chk("refill.mreq", 32'(mgr_req.req), 1);
        chk_g("refill", 1, 0);
        step();
        drv(0, 0, 0, 1, 32'h0);
        chk_rv("drain1", 0, 1);
        step();
        drv(0, 0, 0, 1, 32'h0);
        chk_rv("drain2", 1, 0);
        step();
        chk("drain.busy", 32'(busy), 0);

        // Same-cycle push (req1) and pop (req0 entry)
        drv(1, 0, 1, 0, 32'h0);
        chk_g("pp.pre", 1, 0);
        step();
        drv(0, 1, 1, 1, 32'h0);
        chk_g("pp", 0, 1);
        chk_rv("pp", 1, 0);
        step();
        chk("pp.busy", 32'(busy), 1);
        drv(0, 0, 0, 1, 32'h0);
        chk_rv("pp.next", 0, 1);
        step();
        chk("pp.busy0", 32'(busy), 0);

        // Lone requester 1 with prio_q = 0, then contention shows prio_q stayed 0
        drv(0, 1, 1, 0, 32'h0);
        chk_g("lone1", 0, 1);
        step();
        drv(1, 1, 1, 0, 32'h0);
        chk_g("lone1.prio", 1, 0);
        step();
        drv(0, 0, 0, 1, 32'h0);
        chk_rv("lone.d1", 0, 1);
        step();
        drv(0, 0, 0, 1, 32'h0);
        chk_rv("lone.d2", 1, 0);
        step();

        // Orphan response
        drv(0, 0, 0, 1, 32'hCAFE_0001);
        chk_rv("orph", 0, 0);
        chk("orph.err0", 32'(err), 0);
        step();
        chk("orph.err1", 32'(err), 1);
        drv(1, 0, 1, 0, 32'h0);
        chk_g("orph.tr", 1, 0);
        step();
        drv(0, 0, 0, 1, 32'h0);
        chk_rv("orph.tr", 1, 0);
        step();
        chk("orph.sticky", 32'(err), 1);
        chk("orph.busy", 32'(busy), 0);

        // Reset with two entries in flight
        drv(1, 1, 1, 0, 32'h0);
        chk_g("rf1", 0, 1);
        step();
        drv(1, 1, 1, 0, 32'h0);
        chk_g("rf2", 1, 0);
        step();
        chk("rf.busy", 32'(busy), 1);
        drv(0, 0, 0, 0, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("arst.busy", 32'(busy), 0);
        chk("arst.err", 32'(err), 0);
        chk("arst.mreq", 32'(mgr_req.req), 0);
        step();
        rst_n = 1'b1;
        drv(0, 0, 0, 1, 32'h0);
        chk_rv("stale1", 0, 0);
        step();
        chk("stale1.err", 32'(err), 1);
        drv(0, 0, 0, 1, 32'h0);
        chk_rv("stale2", 0, 0);
        step();
        chk("stale2.err", 32'(err), 1);
        chk("stale.busy", 32'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/user_obi_mgr_arbiter.md
USER_OBI_MGR_ARBITER -- requirements
Module: user_obi_mgr_arbiter

Interface
REQ-001 Parameter ObiCfg, obi_pkg::ObiDefaultConfig, OBI configuration shared by both requesters and the shared manager port.
REQ-002 Parameter obi_req_t, logic, OBI manager request struct type (req, a.addr, a.we, a.be, a.wdata, a.aid).
REQ-003 Parameter obi_rsp_t, logic, OBI manager response struct type (gnt, rvalid, r.rdata, r.rid, r.err).
REQ-004 Parameter MaxOutstanding, 2, depth of the in-flight routing FIFO; legal range 1..8.
REQ-005 clk_i  input  1  single clock; all state is updated on its rising edge.
REQ-006 rst_ni  input  1  asynchronous, active-low reset.
REQ-007 req0_i  input  obi_req_t  request from requester 0 (threshold streamer).
REQ-008 rsp0_o  output  obi_rsp_t  response to requester 0.
REQ-009 req1_i  input  obi_req_t  request from requester 1 (second datapath or DMA).
REQ-010 rsp1_o  output  obi_rsp_t  response to requester 1.
REQ-011 mgr_req_o  output  obi_req_t  shared request to the SRAM-side OBI port.
REQ-012 mgr_rsp_i  input  obi_rsp_t  shared response from the SRAM-side OBI port.
REQ-013 busy_o  output  1  high while the routing FIFO is non-empty.
REQ-014 err_o  output  1  sticky flag, set by an orphan rvalid.

Function
REQ-015 Arbitration SHALL be combinational within the cycle.
- mgr_req_o.req = (req0_i.req | req1_i.req) & !fifo_full.
- mgr_req_o.a SHALL be driven from the selected requester.
REQ-016 Selection rule:
- Only one requester active: that requester is selected.
- Both active: the requester named by the 1-bit priority pointer prio_q is selected.
REQ-017 rspN_o.gnt SHALL be mgr_rsp_i.gnt & mgr_req_o.req & (selected == N); the non-selected requester sees gnt = 0.
REQ-018 A handshake (mgr_req_o.req & mgr_rsp_i.gnt) SHALL push the selected index into the routing FIFO.
REQ-019 A handshake SHALL set prio_q to the non-selected index; with no handshake, prio_q holds.
REQ-020 While fifo_full, mgr_req_o.req SHALL be 0 and no gnt SHALL reach either requester, even if mgr_rsp_i.gnt = 1.
REQ-021 mgr_rsp_i.rvalid with the FIFO non-empty SHALL:
- pop the FIFO head;
- assert rvalid on rsp<head>_o only, in the same cycle;
- pass r.rdata, r.err and r.rid through unchanged.
REQ-022 Simultaneous push and pop in one cycle SHALL leave occupancy unchanged and preserve FIFO order.
- When full, pop-then-push in one cycle is not allowed; REQ-020 blocks the push.
REQ-023 mgr_rsp_i.rvalid with the FIFO empty SHALL:
- be dropped, with rvalid = 0 on both rsp outputs;
- set err_o to 1.
- err_o stays 1 until reset.
REQ-024 Responses SHALL be routed strictly in grant order; occupancy SHALL never exceed MaxOutstanding.
REQ-025 busy_o SHALL equal (occupancy != 0), registered.
REQ-026 The FIFO occupancy counter SHALL be $clog2(MaxOutstanding+1) bits wide; read and write pointers SHALL wrap modulo MaxOutstanding.

Reset
REQ-027 While rst_ni = 0, asynchronously:
- prio_q = 0;
- FIFO empty, both pointers 0;
- err_o = 0;
- busy_o = 0.
REQ-028 During and immediately after reset, the following SHALL be 0 until inputs request otherwise:
- mgr_req_o.req;
- both rspN_o.gnt;
- both rspN_o.rvalid.
REQ-029 Reset asserted mid-transaction SHALL discard all in-flight routing entries; later orphan rvalids follow REQ-023.

Verification
REQ-030 Both requesters hold req, gnt = 1 every cycle, rvalid one cycle after each gnt -> grants alternate 0,1,0,1; each requester gets 2 of the first 4 grants; responses arrive on the matching port.
REQ-031 MaxOutstanding = 2, gnt = 1, rvalid withheld -> two grants, then mgr_req_o.req = 0 and busy_o = 1; one rvalid -> one further grant issued the next cycle.
REQ-032 Grant to requester 1 and rvalid for a prior requester-0 entry in the same cycle -> rsp0_o.rvalid = 1, FIFO occupancy unchanged at 1, next rvalid routed to requester 1.
REQ-033 rvalid with rdata 32'hCAFE0001 and empty FIFO -> neither rsp port shows rvalid, err_o = 1 from the next cycle and remains 1 through further traffic.
REQ-034 Only requester 1 active with prio_q = 0 -> requester 1 granted immediately, prio_q becomes 0.
REQ-035 Two grants outstanding, rst_ni pulsed low -> busy_o = 0 and err_o = 0 asynchronously; both stale rvalids after release set err_o = 1.
